// File: rtl/adder_pkg.sv
// Shared FSM state encoding and add/subtract mode constants for the bit-serial adder.
// Pure declarations: no latency and no flow control of its own.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell; the only arithmetic element in the serial datapath.
// Purely combinational, zero latency, no flow control.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial two's complement add/subtract, LSB first through one fa_cell; result after WIDTH cycles.
// start_in only accepted in IDLE (busy_out/done_out high means it is ignored); one op per WIDTH+2 cycles.
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic fa_a, fa_b, fa_ci, fa_s, fa_co;

    fa_cell u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_ci),
        .sum  (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // Subtract is A + ~B + ~borrow_in, so B and the initial carry are inverted per bit.
        fa_a  = a_q[0];
        fa_b  = b_q[0] ^ (sub_q == SUB);
        fa_ci = carry_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = SHIFT;
                    a_d     = a_in;
                    b_d     = b_in;
                    sub_d   = sub_in;
                    carry_d = c_in ^ (sub_in == SUB);
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                // A's register doubles as the result accumulator: sum bits enter at the top.
                a_d     = {fa_s, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = {fa_s, a_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign sum_out      = sum_q;
    assign carry_out    = cout_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=8: directed vectors, abort by reset, ignored start, back-to-back starts.
module tb_bit_serial_adder;
    import adder_pkg::*;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         start_in = 1'b0;
    logic         sub_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         c_in = 1'b0;
    logic         busy_out, done_out, carry_out, overflow_out;
    logic [W-1:0] sum_out;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .sub_in       (sub_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .sum_out      (sum_out),
        .carry_out    (carry_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         c;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [W-1:0] held_sum = '0;
    logic         held_carry = 1'b0;
    logic         held_ovf = 1'b0;
    logic         prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rst_in) begin
            held_sum   = '0;
            held_carry = 1'b0;
            held_ovf   = 1'b0;
        end
    end

    // Monitor: pops an expectation on every done pulse; while busy the visible result must hold.
    always @(negedge clk_in) begin
        exp_t e;
        if (done_out) begin
            chk("done_width", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", {56'd0, sum_out}, {56'd0, e.sum});
                chk("carry", {63'd0, carry_out}, {63'd0, e.carry});
                chk("ovf", {63'd0, overflow_out}, {63'd0, e.ovf});
                chk("latency", 64'(cyc - e.acc), 64'(W));
                held_sum   = e.sum;
                held_carry = e.carry;
                held_ovf   = e.ovf;
            end
        end else if (busy_out) begin
            chk("held_sum", {56'd0, sum_out}, {56'd0, held_sum});
            chk("held_flags", {62'd0, carry_out, overflow_out}, {62'd0, held_carry, held_ovf});
        end
        prev_done = done_out;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_in);
        while ((busy_out || done_out) && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_op(input vec_t v, input bit pulse_start);
        wait_idle();
        a_in     = v.a;
        b_in     = v.b;
        sub_in   = v.sub;
        c_in     = v.c;
        start_in = 1'b1;
        exp_q.push_back('{sum: v.sum, carry: v.carry, ovf: v.ovf, acc: cyc + 1});
        @(negedge clk_in);
        start_in = 1'b0;
        a_in     = 8'($urandom);
        b_in     = 8'($urandom);
        sub_in   = 1'($urandom);
        c_in     = 1'($urandom);
        chk("busy_after_accept", {63'd0, busy_out}, 64'd1);
        if (pulse_start) begin
            repeat (2) @(negedge clk_in);
            a_in     = 8'h55;
            b_in     = 8'h22;
            sub_in   = SUB;
            start_in = 1'b1;
            @(negedge clk_in);
            start_in = 1'b0;
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{a: 8'h0F, b: 8'h01, sub: ADD, c: 1'b0, sum: 8'h10, carry: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: ADD, c: 1'b1, sum: 8'h01, carry: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, sub: ADD, c: 1'b0, sum: 8'h80, carry: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h05, b: 8'h07, sub: SUB, c: 1'b0, sum: 8'hFE, carry: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, sub: SUB, c: 1'b0, sum: 8'h7F, carry: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, sub: SUB, c: 1'b1, sum: 8'hFF, carry: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h80, b: 8'h80, sub: ADD, c: 1'b0, sum: 8'h00, carry: 1'b1, ovf: 1'b1};
        vecs[7] = '{a: 8'h7F, b: 8'hFF, sub: SUB, c: 1'b0, sum: 8'h80, carry: 1'b0, ovf: 1'b1};

        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("reset_outputs", {52'd0, busy_out, done_out, sum_out, carry_out, overflow_out}, 64'd0);
        rst_in = 1'b0;

        for (int i = 0; i < 8; i++) do_op(vecs[i], 1'b0);

        // Abort after bit 3 with a coincident start that must be lost.
        wait_idle();
        a_in = 8'h33; b_in = 8'h44; sub_in = ADD; c_in = 1'b0;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (4) @(negedge clk_in);
        rst_in   = 1'b1;
        start_in = 1'b1;
        @(negedge clk_in);
        rst_in   = 1'b0;
        start_in = 1'b0;
        chk("abort_outputs", {52'd0, busy_out, done_out, sum_out, carry_out, overflow_out}, 64'd0);
        @(negedge clk_in);
        chk("abort_idle", {62'd0, busy_out, done_out}, 64'd0);

        do_op('{a: 8'h02, b: 8'h03, sub: ADD, c: 1'b0, sum: 8'h05, carry: 1'b0, ovf: 1'b0}, 1'b0);
        do_op('{a: 8'h01, b: 8'h01, sub: ADD, c: 1'b0, sum: 8'h02, carry: 1'b0, ovf: 1'b0}, 1'b1);

        // Start held high: the second accept lands WIDTH+2 edges after the first.
        wait_idle();
        a_in = 8'h10; b_in = 8'h20; sub_in = ADD; c_in = 1'b0;
        start_in = 1'b1;
        exp_q.push_back('{sum: 8'h30, carry: 1'b0, ovf: 1'b0, acc: cyc + 1});
        exp_q.push_back('{sum: 8'h30, carry: 1'b0, ovf: 1'b0, acc: cyc + 1 + W + 2});
        repeat (W + 3) @(negedge clk_in);
        start_in = 1'b0;
        chk("second_accept_busy", {63'd0, busy_out}, 64'd1);

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk_in);
        repeat (3) @(negedge clk_in);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
